// File: rtl/ext_pipe.sv
// ext_pipe: immediate-extension unit feeding a valid/ready register pipeline.
// The extension result is formed combinationally from in_imm/in_mode, then
// travels through STAGES skid-free registers that advance whenever the next
// stage (or the consumer) frees a slot. xfer_cnt counts completed output
// transfers and wraps naturally at 16 bits.
module ext_pipe #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  // Reject parameter sets the datapath cannot represent.
  if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
    $error("ext_pipe: IN_W must be in 2..32");
  end
  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("ext_pipe: OUT_W must be at least IN_W+2");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("ext_pipe: STAGES must be in 1..4");
  end

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_ext;

  logic [STAGES-1:0] r_valid;
  logic [OUT_W-1:0]  r_data [STAGES];
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_vsrc;
  logic [OUT_W-1:0]  w_src  [STAGES];
  logic [15:0]       r_xfer_cnt;

  assign w_zext  = {{(OUT_W-IN_W){1'b0}}, in_imm};
  assign w_sext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign w_upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

  // Select the extended immediate for the requested mode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_ext = w_zext;
    case (in_mode)
      MODE_ZERO:   w_ext = w_zext;
      MODE_SIGN:   w_ext = w_sext;
      MODE_UPPER:  w_ext = w_upper;
      MODE_BRANCH: w_ext = w_sext << 2;
      default:     w_ext = w_zext;
    endcase
  end

  // Ready chain from the consumer back to stage 0: a stage may load when it
  // is empty or its entry leaves this cycle.
  always_comb begin
    logic w_chain_rdy;
    w_load = '0;
    // NOTE: combinational logic uses blocking '=' so each line sees the value computed just above it.
    w_chain_rdy = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_chain_rdy = !r_valid[i] || w_chain_rdy;
      w_load[i]   = w_chain_rdy;
    end
  end

  // Source of each stage: the extension result for stage 0, the previous stage otherwise.
  always_comb begin
    w_vsrc    = '0;
    w_vsrc[0] = in_valid;
    w_src[0]  = w_ext;
    for (int i = 1; i < STAGES; i++) begin
      w_vsrc[i] = r_valid[i-1];
      w_src[i]  = r_data[i-1];
    end
  end

  // Stage valid bits: cleared by reset or flush, otherwise advance on load.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking '<=' so all stages update from pre-edge values.
    if (!reset_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_load[i]) r_valid[i] <= w_vsrc[i];
      end
    end
  end

  // Stage data registers: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    // NOTE: data storage is deliberately left unreset; only the valid bits need a known state.
    for (int i = 0; i < STAGES; i++) begin
      if (w_load[i]) r_data[i] <= w_src[i];
    end
  end

  // Completed output transfer counter; a transfer on a flush edge still counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xfer_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign in_ready  = w_load[0] && !flush;
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: three ext_pipe instances (STAGES = 1, 2, 3) share one stimulus
// stream. Each accepted input pushes its hand-computed expected result into
// that instance's queue; a negedge monitor pops and compares on every output
// transfer and checks that stalled outputs hold steady.
module tb_ext_pipe;

  localparam int N = 3;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        flush;
  logic        out_ready;
  logic [31:0] cur_exp;

  logic        w_in_ready  [N];
  logic        w_out_valid [N];
  logic [31:0] w_out_data  [N];
  logic [15:0] w_xfer_cnt  [N];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [N][$];
  logic        had_stall [N] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] last_data [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    ext_pipe #(
      .IN_W  (16),
      .OUT_W (32),
      .STAGES(g + 1)
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (w_in_ready[g]),
      .in_imm   (in_imm),
      .in_mode  (in_mode),
      .flush    (flush),
      .out_valid(w_out_valid[g]),
      .out_ready(out_ready),
      .out_data (w_out_data[g]),
      .xfer_cnt (w_xfer_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare on output transfers, record accepted inputs.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!reset_n) begin
        exp_q[k].delete();
        had_stall[k] = 1'b0;
      end else begin
        if (had_stall[k]) begin
          check($sformatf("hold_valid_s%0d", k + 1), 32'(w_out_valid[k]), 32'd1);
          check($sformatf("hold_data_s%0d", k + 1), w_out_data[k], last_data[k]);
        end
        if (w_out_valid[k] && out_ready) begin
          if (exp_q[k].size() == 0)
            check($sformatf("unexpected_out_s%0d", k + 1), 32'(exp_q[k].size()), 32'd1);
          else
            check($sformatf("out_data_s%0d", k + 1), w_out_data[k], exp_q[k].pop_front());
        end
        had_stall[k] = w_out_valid[k] && !out_ready;
        last_data[k] = w_out_data[k];
        if (in_valid && w_in_ready[k]) exp_q[k].push_back(cur_exp);
        if (flush) begin
          exp_q[k].delete();
          had_stall[k] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    cur_exp  = exp;
    step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset_n  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Directed vectors for the modes test (imm 0x8001) and the backpressure test.
  logic [15:0] mode_imm;
  logic [31:0] mode_exp [4] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004};
  logic [15:0] bp_imm   [5] = '{16'h7FFF, 16'h0003, 16'hFFFF, 16'h1234, 16'h8000};
  logic [1:0]  bp_mode  [5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
  logic [31:0] bp_exp   [5] = '{32'h0000_7FFF, 32'h0000_000C, 32'h0000_FFFF, 32'h1234_0000, 32'hFFFF_8000};
  logic [15:0] cnt_after_bp [N] = '{16'd1, 16'd2, 16'd3};
  logic [15:0] cnt_after_fl [N] = '{16'd3, 16'd2, 16'd1};

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '0;
    mode_imm  = 16'h8001;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_out_valid_s%0d", k + 1), 32'(w_out_valid[k]), 32'd0);
      check($sformatf("rst_xfer_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'd0);
      check($sformatf("rst_in_ready_s%0d", k + 1), 32'(w_in_ready[k]), 32'd1);
    end
    step();
    reset_n = 1'b1;
    step();

    // Modes: each result on the STAGES=1 instance one cycle after acceptance.
    for (int m = 0; m < 4; m++) begin
      drive(mode_imm, 2'(m), mode_exp[m]);
      check($sformatf("mode%0d_valid_s1", m), 32'(w_out_valid[0]), 32'd1);
      check($sformatf("mode%0d_data_s1", m), w_out_data[0], mode_exp[m]);
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Latency and throughput: 8 back-to-back inputs through the 3-stage instance.
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      if (e <= 8) begin
        in_valid = 1'b1;
        in_imm   = 16'(e);
        in_mode  = 2'b01;
        cur_exp  = 32'(e);
      end else begin
        in_valid = 1'b0;
      end
      step();
      check($sformatf("lat_valid_s3_edge%0d", e), 32'(w_out_valid[2]), 32'((e >= 3) && (e <= 10)));
    end
    for (int k = 0; k < N; k++)
      check($sformatf("lat_xfer_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'd8);

    // Backpressure: consumer stalls for 5 cycles under continuous input.
    do_reset();
    out_ready = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      in_valid = 1'b1;
      in_imm   = bp_imm[e-1];
      in_mode  = bp_mode[e-1];
      cur_exp  = bp_exp[e-1];
      step();
      check($sformatf("bp_in_ready_s1_edge%0d", e), 32'(w_in_ready[0]), 32'd0);
      if (e >= 2) begin
        check($sformatf("bp_in_ready_s2_edge%0d", e), 32'(w_in_ready[1]), 32'd0);
        check($sformatf("bp_out_valid_s2_edge%0d", e), 32'(w_out_valid[1]), 32'd1);
        check($sformatf("bp_out_data_s2_edge%0d", e), w_out_data[1], bp_exp[0]);
      end
      if (e >= 3)
        check($sformatf("bp_in_ready_s3_edge%0d", e), 32'(w_in_ready[2]), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    for (int k = 0; k < N; k++)
      check($sformatf("bp_xfer_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'(cnt_after_bp[k]));

    // Flush: full 3-stage pipeline, head transfers on the flush edge, rest dropped.
    do_reset();
    drive(16'h0010, 2'b00, 32'h0000_0010);
    drive(16'h0020, 2'b11, 32'h0000_0080);
    drive(16'hFFF0, 2'b01, 32'hFFFF_FFF0);
    in_valid = 1'b1;
    in_imm   = 16'h00AA;
    in_mode  = 2'b10;
    cur_exp  = 32'h00AA_0000;
    flush    = 1'b1;
    #1;
    for (int k = 0; k < N; k++)
      check($sformatf("flush_in_ready_s%0d", k + 1), 32'(w_in_ready[k]), 32'd0);
    check("flush_head_valid_s3", 32'(w_out_valid[2]), 32'd1);
    check("flush_head_data_s3", w_out_data[2], 32'h0000_0010);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("flush_out_valid_s%0d", k + 1), 32'(w_out_valid[k]), 32'd0);
      check($sformatf("flush_in_ready_after_s%0d", k + 1), 32'(w_in_ready[k]), 32'd1);
      check($sformatf("flush_xfer_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'(cnt_after_fl[k]));
    end
    repeat (3) step();
    for (int k = 0; k < N; k++)
      check($sformatf("flush_quiet_s%0d", k + 1), 32'(w_out_valid[k]), 32'd0);

    // Counter wrap: 0xFFFF transfers, then one more rolls over to zero.
    do_reset();
    in_mode = 2'b00;
    for (int i = 0; i < 65535; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'(i);
      cur_exp  = {16'h0000, 16'(i)};
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < N; k++)
      check($sformatf("wrap_pre_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'h0000_FFFF);
    drive(16'hFFFF, 2'b01, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    repeat (4) step();
    for (int k = 0; k < N; k++)
      check($sformatf("wrap_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'h0000_0000);

    // Reset mid-stream, asserted between clock edges.
    drive(16'hC000, 2'b11, 32'hFFFF_0000);
    drive(16'h0005, 2'b00, 32'h0000_0005);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("midrst_out_valid_s%0d", k + 1), 32'(w_out_valid[k]), 32'd0);
      check($sformatf("midrst_xfer_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'd0);
      check($sformatf("midrst_in_ready_s%0d", k + 1), 32'(w_in_ready[k]), 32'd1);
    end
    step();
    step();
    reset_n = 1'b1;
    repeat (4) begin
      step();
      for (int k = 0; k < N; k++) begin
        check($sformatf("postrst_out_valid_s%0d", k + 1), 32'(w_out_valid[k]), 32'd0);
        check($sformatf("postrst_xfer_cnt_s%0d", k + 1), 32'(w_xfer_cnt[k]), 32'd0);
      end
    end

    for (int k = 0; k < N; k++)
      check($sformatf("queue_drained_s%0d", k + 1), 32'(exp_q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
